// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, oversampled start/data/stop
// sampling, and one-cycle data_valid / frame_err strobes.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic       i_bit,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfM1 = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          state_q;
  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shreg_q;
  logic [7:0]      data_q;
  logic            valid_q, err_q;

  // Two-flop synchronizer; resets to the idle line level so reset is not a start bit.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_bit;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM with counters, shift register and registered strobes.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!sync2_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfM1) begin
            // Mid start bit: a line already back high was a glitch.
            if (!sync2_q) begin
              state_q <= StData;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == FullM1) begin
            shreg_q <= {sync2_q, shreg_q[7:1]};
            cnt_q   <= '0;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == FullM1) begin
            cnt_q <= '0;
            if (sync2_q) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              err_q   <= 1'b1;
              state_q <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StBreak: begin
          // Wait out a held-low line so it yields only one frame_err.
          if (sync2_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    data_out   = data_q;
    data_valid = valid_q;
    frame_err  = err_q;
    rx_busy    = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx with a frame-level reference model.
module tb_uart_rx;

  localparam int Os = 16;
  // Stop bit sampled at edge 2+Os/2+9*Os; strobe visible in the following cycle.
  localparam int StrobeOfs = 2 + Os / 2 + 9 * Os + 1;

  logic       baud_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       i_bit    = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, frame_err, rx_busy;

  uart_rx #(.OVERSAMPLE(Os)) dut (
    .baud_clk  (baud_clk),
    .rst_n     (rst_n),
    .i_bit     (i_bit),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 baud_clk = ~baud_clk;

  int edge_n = 0;
  always @(posedge baud_clk) edge_n <= edge_n + 1;

  // Observation only: counts strobe cycles and records when they happened.
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, busy_cycles = 0;
  int valid_edge = 0, err_edge = 0;
  always @(negedge baud_clk) begin
    if (data_valid) begin
      valid_cnt  <= valid_cnt + 1;
      valid_edge <= edge_n;
    end
    if (frame_err) begin
      err_cnt  <= err_cnt + 1;
      err_edge <= edge_n;
    end
    if (data_valid && frame_err) both_cnt <= both_cnt + 1;
    if (rx_busy) busy_cycles <= busy_cycles + 1;
  end

  int         n_cmp = 0, n_bad = 0;
  int         exp_valid = 0, exp_err = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    i_bit = b;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid_cnt"}, valid_cnt, exp_valid);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_data"}, {24'h0, data_out}, {24'h0, exp_data});
  endtask

  // Sends one frame starting at a negedge; the model decides the outcome.
  task automatic send(input logic [7:0] b, input logic stop, input string tag);
    int s;
    s = edge_n;
    drive(1'b0, Os);
    for (int k = 0; k < 8; k++) drive(b[k], Os);
    drive(stop, Os);
    if (stop) begin
      exp_valid++;
      exp_data = b;
      check({tag, "_valid_time"}, valid_edge, s + StrobeOfs);
    end else begin
      exp_err++;
      check({tag, "_err_time"}, err_edge, s + StrobeOfs);
    end
    check_state(tag);
    // After a bad stop bit the line must go high to leave the break wait.
    if (!stop) drive(1'b1, Os);
  endtask

  initial begin
    int         e1, s, b0;
    logic [7:0] rb, c3;
    logic       rs;

    repeat (3) @(negedge baud_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge baud_clk);
    check("reset_data", {24'h0, data_out}, 32'h0);
    check("reset_valid", {31'h0, data_valid}, 32'h0);
    check("reset_err", {31'h0, frame_err}, 32'h0);
    check("reset_busy", {31'h0, rx_busy}, 32'h0);

    send(8'hA5, 1'b1, "single_a5");

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1, "b2b_00");
    e1 = valid_edge;
    send(8'hFF, 1'b1, "b2b_ff");
    check("b2b_spacing", valid_edge - e1, 32'd160);
    drive(1'b1, Os);

    // Short low glitch on an idle line.
    b0 = busy_cycles;
    drive(1'b0, 4);
    drive(1'b1, 3 * Os);
    check("glitch_busy_seen", {31'h0, (busy_cycles > b0)}, 32'd1);
    check("glitch_busy_now", {31'h0, rx_busy}, 32'h0);
    check_state("glitch");

    // Framing error, then a good frame.
    send(8'h3C, 1'b0, "ferr_3c");
    send(8'h11, 1'b1, "ferr_11");
    drive(1'b1, Os);

    // Line held low for 20 bit times.
    s = edge_n;
    drive(1'b0, 20 * Os);
    drive(1'b1, 2 * Os);
    exp_err++;
    check("break_err_time", err_edge, s + StrobeOfs);
    check_state("break");
    send(8'h5A, 1'b1, "break_5a");

    // Randomized frames, some with a bad stop bit.
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send(rb, rs, $sformatf("rand%0d", i));
    end
    drive(1'b1, Os);

    // Reset during data bit 4 of 0xC3.
    c3 = 8'hC3;
    drive(1'b0, Os);
    for (int k = 0; k < 4; k++) drive(c3[k], Os);
    drive(c3[4], Os / 2);
    rst_n = 1'b0;
    i_bit = 1'b1;
    #1;
    check("midrst_data", {24'h0, data_out}, 32'h0);
    check("midrst_busy", {31'h0, rx_busy}, 32'h0);
    check("midrst_valid", {31'h0, data_valid}, 32'h0);
    check("midrst_err", {31'h0, frame_err}, 32'h0);
    repeat (3) @(negedge baud_clk);
    rst_n = 1'b1;
    exp_data = 8'h00;
    drive(1'b1, 3 * Os);
    check_state("midrst_after");
    send(8'h7E, 1'b1, "midrst_7e");

    check("pulse_overlap", both_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 UART link driven by the team's `uart` transmitter. It takes the asynchronous serial line, oversamples it on `baud_clk`, recovers one byte per frame, and presents the byte with a single-cycle valid strobe. Framing errors are flagged on a separate strobe. It sits at the board-facing edge of the design, feeding byte consumers such as command parsers and FIFOs.

## Interface
- `OVERSAMPLE`, default 16: `baud_clk` cycles per bit period. Must be even and ≥ 4.
- `baud_clk`  in  1  Single clock, running at `OVERSAMPLE` × bit rate. All logic is clocked on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `i_bit`  in  1  Serial line. Asynchronous to `baud_clk`. Idle level is 1.
- `data_out`  out  8  Last correctly framed byte. Bit 0 is the first data bit received.
- `data_valid`  out  1  One-cycle pulse when `data_out` is updated.
- `frame_err`  out  1  One-cycle pulse when the stop bit samples 0.
- `rx_busy`  out  1  High whenever the state is not IDLE.

## Operation
- **Input synchronizer.** `i_bit` passes through a 2-flop synchronizer (`sync1`, `sync2`), both reset to 1. All decisions use `sync2`.
- **Counters.** Sample counter `cnt` is log2(`OVERSAMPLE`) bits wide. Bit index `idx` is 3 bits wide. Shift register `shreg` is 8 bits wide.
- **IDLE.** When `sync2`=0, go to START with `cnt`=0.
- **START.** Count up to `cnt`=`OVERSAMPLE`/2−1. On the following edge (mid start bit), check `sync2`:
  - 0: go to DATA with `cnt`=0 and `idx`=0.
  - 1: treat as a glitch and return to IDLE. No outputs change.
- **DATA.** When `cnt`=`OVERSAMPLE`−1:
  - Shift `sync2` into `shreg` MSB-first-in, right shift, so the first bit ends at `shreg[0]`.
  - Reset `cnt` to 0 and increment `idx`.
  - After the 8th sample (`idx`=7 at sampling), go to STOP.
- **STOP.** When `cnt`=`OVERSAMPLE`−1, sample `sync2`:
  - 1: load `data_out`←`shreg`, pulse `data_valid`, go to IDLE. This happens mid stop bit, so back-to-back frames are accepted.
  - 0: pulse `frame_err`, leave `data_out` unchanged, go to BREAK.
- **BREAK.** Stay here until `sync2`=1, then go to IDLE. A held-low line therefore produces exactly one `frame_err` and no spurious frames.
- **Pulse rule.** `data_valid` and `frame_err` are never high in the same cycle. Each is high for exactly one cycle per frame.

## Timing
- **Reset values.**
  - `data_out`=0x00, `data_valid`=0, `frame_err`=0, `rx_busy`=0.
  - State is IDLE; `cnt`, `idx` and `shreg` are 0.
  - `sync1`=`sync2`=1.
- **Reset mid-frame.** The frame is abandoned immediately and no strobe is produced. After release, reception resumes at the next falling edge of `sync2`.
- **Edge numbering.** Edge 0 is the first `baud_clk` edge that samples `i_bit`=0 into `sync1`.
  - IDLE→START occurs at edge 2.
  - Start-bit check occurs at edge 2+`OVERSAMPLE`/2.
  - Data bit k is sampled at edge 2+`OVERSAMPLE`/2+(k+1)·`OVERSAMPLE`.
  - The stop bit is sampled at edge 2+`OVERSAMPLE`/2+9·`OVERSAMPLE`. `data_valid` or `frame_err` is high in the cycle after that edge. For `OVERSAMPLE`=16 this is edge 154.
- **`rx_busy`.** Rises the cycle after edge 2. Falls in the same cycle that `data_valid` rises, or when BREAK exits.
- **Glitch filter.** A low pulse that has cleared `sync2` before the mid-start check is rejected. For `OVERSAMPLE`=16, any low pulse of ≤ 7 cycles is rejected.
- **Back-to-back frames.** A new start bit may begin any time after the stop-bit sample. IDLE re-detects it within 3 cycles of the falling edge.

## Test plan
- **Single frame.** Reset, then send 0xA5 at 16 cycles/bit (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → `data_valid` for one cycle at edge 154 with `data_out`=0xA5. `frame_err` stays 0.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap → two `data_valid` pulses exactly 160 cycles apart, with `data_out` 0x00 then 0xFF.
- **Glitch rejection.** Drive a 4-cycle low pulse on an idle line → `rx_busy` pulses briefly and returns to 0. No `data_valid`, no `frame_err`, `data_out` unchanged.
- **Framing error.** Send 0x3C with stop bit 0, then a valid 0x11 → one `frame_err` pulse and `data_out` still at its previous value. After the line returns high, 0x11 is received with `data_valid`.
- **Break.** Hold `i_bit` low for 20 bit times, then high for 2 bit times, then send 0x5A → exactly one `frame_err`, no `data_valid` during the break, then 0x5A received.
- **Reset mid-frame.** Assert `rst_n`=0 during data bit 4 of 0xC3, release, then send 0x7E → no strobe for the aborted frame, outputs at reset values, then `data_valid` with 0x7E.
